// File: rtl/start_stop_debouncer.sv
// start_stop_debouncer: synchronizes and debounces the start/stop button,
// then turns each clean press into a one-cycle press pulse and a run toggle.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   btn_raw    in   raw asynchronous button input
//   btn_level  out  debounced button level
//   press      out  one-cycle pulse per accepted press
//   run        out  toggles on each press (stopwatch start_stop)
//   clear      out  one-cycle long-press pulse (LONG_PRESS_EN only)
//
// Build option: define LONG_PRESS_EN to add the long-press clear.
module start_stop_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 200_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press,
  output logic run,
  output logic clear
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    PRESSED,
    WAIT_LOW
  } state_e;

  logic          s1_q, s1_d;
  logic          sync_q, sync_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          run_q, run_d;
  logic          clear_q, clear_d;

`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
  logic [HW-1:0] hold_q, hold_d;
`else
  localparam bit CFG_OK = LONG_PRESS_CYCLES > DEBOUNCE_CYCLES;
`endif

  always_comb begin
    s1_d    = btn_raw;
    sync_d  = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE_LOW: begin
        if (sync_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (!sync_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CW'(1);
        end
      end
      WAIT_LOW: begin
        if (sync_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    // Outputs are decoded from the next state so they register
    // on the same edge as the state change.
    level_d = (state_d == PRESSED) || (state_d == WAIT_LOW);
    press_d = (state_q == WAIT_HIGH) && (state_d == PRESSED);
    run_d   = run_q ^ press_d;

`ifdef LONG_PRESS_EN
    hold_d  = hold_q;
    clear_d = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if ((state_q == PRESSED) || (state_q == WAIT_LOW)) begin
      // Saturating: one clear per press at most.
      if (hold_q != HOLD_MAX) begin
        hold_d  = hold_q + HW'(1);
        clear_d = (hold_q == HOLD_MAX - HW'(1));
      end
    end
    if (clear_d) run_d = 1'b0;
`else
    clear_d = 1'b0 & CFG_OK;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      run_q   <= 1'b0;
      clear_q <= 1'b0;
`ifdef LONG_PRESS_EN
      hold_q  <= '0;
`endif
    end else begin
      s1_q    <= s1_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      run_q   <= run_d;
      clear_q <= clear_d;
`ifdef LONG_PRESS_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign btn_level = level_q;
  assign press     = press_q;
  assign run       = run_q;
  assign clear     = clear_q;

endmodule

// File: tb/tb_start_stop_debouncer.sv
// tb_start_stop_debouncer: table vectors, directed corner sequences
// and randomized button activity against a behavioural model.
module tb_start_stop_debouncer;

  localparam int D = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic btn_level, press, run, clear;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  start_stop_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .press(press),
    .run(run),
    .clear(clear)
  );

  // Behavioural model: a level flips once the synchronized input has
  // disagreed with it for D+1 consecutive samples.
  logic m_s1, m_sync, m_level, m_run, m_press, m_clear;
  int m_disagree, m_hold;

  task automatic model_step(input logic r, input logic b);
    logic prev_level;
    m_press = 1'b0;
    m_clear = 1'b0;
    if (r) begin
      m_s1 = 0; m_sync = 0; m_level = 0; m_run = 0;
      m_disagree = 0; m_hold = 0;
    end else begin
      prev_level = m_level;
      if (m_sync != m_level) begin
        m_disagree++;
        if (m_disagree == D + 1) begin
          m_level = ~m_level;
          m_disagree = 0;
          if (m_level) m_press = 1'b1;
        end
      end else begin
        m_disagree = 0;
      end
`ifdef LONG_PRESS_EN
      if (m_press) m_hold = 0;
      else if (prev_level && m_hold < L) begin
        m_hold++;
        if (m_hold == L) m_clear = 1'b1;
      end
`endif
      m_sync = m_s1;
      m_s1 = b;
      if (m_press) m_run = ~m_run;
      if (m_clear) m_run = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic b);
    reset = r;
    btn_raw = b;
    @(posedge clk);
    model_step(r, b);
    #1;
    cyc++;
    chk("btn_level", btn_level, m_level);
    chk("press", press, m_press);
    chk("run", run, m_run);
    chk("clear", clear, m_clear);
  endtask

  typedef struct {
    logic rst;
    logic raw;
    logic lvl;
    logic prs;
    logic run;
  } vec_t;

  vec_t tbl[26];

  initial begin : main
    int pcnt, ccnt, pidx, cidx, n;
    logic v;

    tbl = '{
      '{1,1,0,0,0}, '{1,1,0,0,0}, '{1,1,0,0,0},
      '{0,1,0,0,0}, '{0,1,0,0,0}, '{0,1,0,0,0},
      '{0,1,0,0,0}, '{0,1,0,0,0}, '{0,1,0,0,0},
      '{0,1,1,1,1}, '{0,1,1,0,1},
      '{0,0,1,0,1}, '{0,0,1,0,1}, '{0,0,1,0,1},
      '{0,0,1,0,1}, '{0,0,1,0,1}, '{0,0,1,0,1},
      '{0,0,0,0,1},
      '{0,1,0,0,1}, '{0,1,0,0,1}, '{0,1,0,0,1},
      '{0,1,0,0,1}, '{0,1,0,0,1}, '{0,1,0,0,1},
      '{0,1,1,1,0}, '{0,1,1,0,0}
    };

    // Reset hold, clean press, release, second press.
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].rst, tbl[i].raw);
      chk("tbl_level", btn_level, tbl[i].lvl);
      chk("tbl_press", press, tbl[i].prs);
      chk("tbl_run", run, tbl[i].run);
      chk("tbl_clear", clear, 1'b0);
    end

    // Bounce 1,1,0,0,1,1,0,0 then hold high.
    step(1, 0); step(1, 0);
    pcnt = 0; pidx = -1;
    for (int i = 0; i < 24; i++) begin
      v = (i >= 8) ? 1'b1 : ((i % 4) < 2);
      step(0, v);
      if (press === 1'b1) begin
        pcnt++;
        if (pidx < 0) pidx = i;
      end
    end
    chk("bounce_one_press", 1'(pcnt == 1), 1'b1);
    chk("bounce_press_idx", 1'(pidx == 14), 1'b1);

    // Release glitch of 3 cycles while pressed.
    pcnt = 0; n = 0;
    for (int i = 0; i < 23; i++) begin
      step(0, (i < 3) ? 1'b0 : 1'b1);
      if (press === 1'b1) pcnt++;
      if (btn_level !== 1'b1) n++;
    end
    chk("glitch_no_press", 1'(pcnt == 0), 1'b1);
    chk("glitch_level_held", 1'(n == 0), 1'b1);

    // Long hold for 40 cycles from reset.
    step(1, 0); step(1, 0);
    pcnt = 0; ccnt = 0; pidx = -1; cidx = -1;
    for (int i = 0; i < 40; i++) begin
      step(0, 1);
      if (press === 1'b1) begin pcnt++; pidx = i; end
      if (clear === 1'b1) begin ccnt++; cidx = i; end
    end
    chk("long_one_press", 1'(pcnt == 1 && pidx == 6), 1'b1);
`ifdef LONG_PRESS_EN
    chk("long_one_clear", 1'(ccnt == 1 && cidx == pidx + L), 1'b1);
    chk("long_run_forced", run, 1'b0);
`else
    chk("long_no_clear", 1'(ccnt == 0), 1'b1);
    chk("long_run_kept", run, 1'b1);
`endif

    // Reset in WAIT_HIGH with count 3, then a fresh full hold.
    step(1, 0); step(1, 0);
    for (int i = 0; i < 5; i++) step(0, 1);
    step(1, 1);
    chk("midrst_level", btn_level, 1'b0);
    chk("midrst_press", press, 1'b0);
    chk("midrst_run", run, 1'b0);
    pidx = -1;
    for (int i = 0; i < 20 && pidx < 0; i++) begin
      step(0, 1);
      if (press === 1'b1) pidx = i;
    end
    chk("midrst_press_idx", 1'(pidx == 6), 1'b1);

    // Randomized segments with occasional reset.
    for (int s = 0; s < 400; s++) begin
      v = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 12);
      if ($urandom_range(0, 49) == 0) step(1, v);
      for (int k = 0; k < n; k++) step(0, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
